// File: rtl/mux_arbiter_8.sv
// Round-robin 8-way arbiter that shares one registered DW-wide output.
// A two-state FSM tracks whether out_data holds an untransferred word.
module mux_arbiter_8 #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    req,
   input  logic [8*DW-1:0] data_in,
   input  logic          out_ready,
   output logic [7:0]    grant,
   output logic [2:0]    sel,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic [15:0]   xfer_count
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    sel_q, sel_d;
   logic [DW-1:0] data_q, data_d;
   logic [15:0]   cnt_q, cnt_d;

   logic [2:0]    win;
   logic [2:0]    idx;
   logic          capture;
   logic          xfer;

   // Scan downward so the lowest offset from ptr wins.
   always_comb begin
      win = ptr_q;
      idx = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr_q + 3'(i);
         if (req[idx]) win = idx;
      end
   end

   always_comb begin
      capture = (|req) && (state_q == IDLE || out_ready);
      xfer    = (state_q == BUSY) && out_ready;
      grant   = '0;
      if (capture && rst_n) grant = 8'b1 << win;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (xfer) begin
         cnt_d   = cnt_q + 16'd1;
         state_d = IDLE;
      end
      if (capture) begin
         state_d = BUSY;
         sel_d   = win;
         ptr_d   = win + 3'd1;
         data_d  = data_in[32'(win)*DW +: DW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel        = sel_q;
   assign out_data   = data_q;
   assign out_valid  = (state_q == BUSY);
   assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux_arbiter_8.sv
// Directed bench for mux_arbiter_8 with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked before the next edge.
module tb_mux_arbiter_8;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    req;
   logic [8*DW-1:0] data_in;
   logic          out_ready;
   logic [7:0]    grant;
   logic [2:0]    sel;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [15:0]   xfer_count;

   int checks = 0;
   int failures = 0;

   mux_arbiter_8 #(.DW(DW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .data_in(data_in),
      .out_ready(out_ready),
      .grant(grant),
      .sel(sel),
      .out_data(out_data),
      .out_valid(out_valid),
      .xfer_count(xfer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] hold_d;
   logic [2:0]  hold_s;
   int k;

   initial begin
      rst_n     = 1'b0;
      req       = 8'hFF;
      out_ready = 1'b0;
      data_in   = '0;
      #3;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_cnt", 32'(xfer_count), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      req = 8'h00;
      #4 rst_n = 1'b1;

      step();
      req = 8'b0000_0100;
      data_in[2*DW +: DW] = 16'hBEEF;
      #1 chk("t31_grant", 32'(grant), 32'h04);
      step();
      req = 8'h00;
      #1;
      chk("t31_valid", 32'(out_valid), 32'd1);
      chk("t31_sel", 32'(sel), 32'd2);
      chk("t31_data", 32'(out_data), 32'hBEEF);
      chk("t31_grant_idle", 32'(grant), 32'd0);
      out_ready = 1'b1;
      step();
      chk("t31_cnt", 32'(xfer_count), 32'd1);
      chk("t31_idle", 32'(out_valid), 32'd0);
      chk("t31_hold_data", 32'(out_data), 32'hBEEF);

      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++)
         data_in[i*DW +: DW] = 16'h1000 + 16'(i);
      step();
      req = 8'hFF;
      out_ready = 1'b1;
      for (k = 0; k < 9; k++) begin
         #1 chk("t32_grant", 32'(grant), 32'(8'b1 << (k % 8)));
         step();
         chk("t32_sel", 32'(sel), 32'(k % 8));
         chk("t32_data", 32'(out_data), 32'h1000 + 32'(k % 8));
         chk("t32_cnt", 32'(xfer_count), 32'(k));
      end

      out_ready = 1'b0;
      hold_d = out_data;
      hold_s = sel;
      for (k = 0; k < 5; k++) begin
         req = (k % 2 == 0) ? 8'h55 : 8'h00;
         #1 chk("t33_grant", 32'(grant), 32'd0);
         step();
         chk("t33_data", 32'(out_data), 32'(hold_d));
         chk("t33_sel", 32'(sel), 32'(hold_s));
         chk("t33_valid", 32'(out_valid), 32'd1);
      end
      req = 8'h00;
      out_ready = 1'b1;
      step();
      chk("t33_cnt", 32'(xfer_count), 32'd9);
      chk("t33_idle", 32'(out_valid), 32'd0);

      req = 8'h80;
      step();
      chk("t34_sel7", 32'(sel), 32'd7);
      req = 8'b1000_0001;
      #1 chk("t34_grant0", 32'(grant), 32'h01);
      step();
      chk("t34_sel0", 32'(sel), 32'd0);
      #1 chk("t34_grant7", 32'(grant), 32'h80);
      step();
      chk("t34_sel7b", 32'(sel), 32'd7);
      req = 8'h00;
      step();
      chk("t34_cnt", 32'(xfer_count), 32'd12);

      req = 8'h04;
      out_ready = 1'b0;
      step();
      chk("t35_sel2", 32'(sel), 32'd2);
      req = 8'hFF;
      #2 rst_n = 1'b0;
      #1;
      chk("t35_valid", 32'(out_valid), 32'd0);
      chk("t35_data", 32'(out_data), 32'd0);
      chk("t35_sel", 32'(sel), 32'd0);
      chk("t35_cnt", 32'(xfer_count), 32'd0);
      chk("t35_grant", 32'(grant), 32'd0);
      #2 rst_n = 1'b1;
      #1 chk("t35_grant0", 32'(grant), 32'h01);
      step();
      chk("t35_win0", 32'(sel), 32'd0);
      chk("t35_cnt0", 32'(xfer_count), 32'd0);

      out_ready = 1'b1;
      for (k = 0; k < 65535; k++) @(posedge clk);
      #1 chk("t36_max", 32'(xfer_count), 32'hFFFF);
      step();
      chk("t36_wrap", 32'(xfer_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_arbiter_8.md
MUX_ARBITER_8 -- requirements
Module: mux_arbiter_8

Interface
REQ-001 Parameter: DW, default 16, data width of each requester lane and of the output.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  8  per-requester request, level-sensitive; bit i = requester i.
REQ-005 Port: data_in  input  8*DW  packed lanes; lane i = data_in[i*DW +: DW].
REQ-006 Port: out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-007 Port: grant  output  8  one-hot, one-cycle pulse: lane captured this cycle.
REQ-008 Port: sel  output  3  index of the lane currently held in out_data.
REQ-009 Port: out_data  output  DW  registered selected lane.
REQ-010 Port: out_valid  output  1  out_data holds an untransferred word.
REQ-011 Port: xfer_count  output  16  count of completed transfers (out_valid & out_ready).

Function
REQ-012 The block SHALL share one DW-wide output among 8 requesters, round-robin, one word per grant.
REQ-013 The block SHALL implement a two-state FSM: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 The block SHALL keep a 3-bit priority pointer ptr; search order is ptr, ptr+1, ..., ptr+7 mod 8.
REQ-015 A capture SHALL occur on any clock edge where (state==IDLE, or BUSY with out_ready=1) and req!=0.
REQ-016 On a capture, the first set req bit in search order SHALL be winner w: sel<=w, out_data<=lane w, grant=one-hot(w) for that cycle, state<=BUSY.
REQ-017 grant SHALL be combinational from the capture condition and pointer, high exactly in the cycle preceding the edge that loads out_data; at all other times grant=0.
REQ-018 On each capture, ptr SHALL be set to w+1 mod 8 (7 wraps to 0).
REQ-019 In BUSY with out_ready=0, out_data, sel and out_valid SHALL hold; grant=0; req changes have no effect.
REQ-020 In BUSY with out_ready=1 and req==0, the transfer SHALL complete and state<=IDLE, out_valid<=0; out_data and sel hold their last value.
REQ-021 In BUSY with out_ready=1 and req!=0, the transfer SHALL complete and the next capture SHALL occur on the same edge: back-to-back, no idle bubble.
REQ-022 In IDLE with req==0, state SHALL remain IDLE and ptr SHALL hold.
REQ-023 Latency: req asserted in IDLE -> out_valid high on the next rising edge (1 cycle).
REQ-024 xfer_count SHALL increment by 1 on each edge with out_valid&out_ready, wrapping 16'hFFFF->0.
REQ-025 A requester SHALL be served at most once per grant; re-service requires req still or again high at a later capture.
REQ-026 Fairness: with all 8 req held high, grants SHALL rotate 0,1,...,7,0 with one grant per transfer.
REQ-027 out_ready while in IDLE SHALL be ignored and SHALL NOT change xfer_count.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk, force state=IDLE, ptr=0, sel=0, out_data=0, out_valid=0, xfer_count=0; grant SHALL read 0 while rst_n is low.
REQ-029 Reset asserted in BUSY SHALL discard the held word: no transfer is counted.
REQ-030 After rst_n deasserts, the first capture SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-031 Reset, then req=8'b0000_0100 with lane2=16'hBEEF for one cycle -> grant=8'h04 for that cycle; next edge out_valid=1, sel=2, out_data=16'hBEEF.
REQ-032 req=8'hFF held, out_ready=1 held, lane i = 16'h1000+i -> sel sequence 0..7,0, one word per cycle, out_data 16'h1000..16'h1007, xfer_count +1 per cycle.
REQ-033 Word held with out_ready=0 for 5 cycles while req toggles -> out_data, sel stable and grant=0 throughout; out_ready=1 -> xfer_count +1.
REQ-034 Last grant=7 (ptr=0), req=8'b1000_0001 -> next winner 0; following capture with both still high -> winner 7.
REQ-035 rst_n pulsed low mid-BUSY, asynchronously between edges -> out_valid, out_data, sel, xfer_count go to 0 immediately; next winner is searched from index 0.
REQ-036 xfer_count preloaded to 16'hFFFF by 65535 transfers, one more transfer -> xfer_count=0.
